// File: rtl/stream_mux_if.sv
// stream_mux_if -- bundle of the stream_mux data-path signals.
//   slave  modport: the multiplexer side (consumes in_*, sel, mode, out_ready;
//                   produces in_ready, out_data, out_chan, out_valid).
//   master modport: the environment side (mirror directions).
// Parameters WIDTH and N must match the stream_mux instance they connect to.
interface stream_mux_if #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned N     = 2
);
    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic               mode;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_chan;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/stream_mux.sv
// stream_mux -- N-channel valid/ready stream multiplexer with one registered
// output stage. Channel choice is either a fixed select (mode=0) or a
// round-robin scan starting at rr_ptr (mode=1).
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : stream_mux_if.slave (in_data/in_valid/in_ready, sel, mode,
//            out_data/out_chan/out_valid/out_ready)
// Build option: define STREAM_MUX_RR_EN to include the round-robin pointer
// and honour mode; without it mode is ignored and only fixed select exists.
module stream_mux #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned N     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    stream_mux_if.slave bus
);
    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic             load;
    logic             xfer;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [N-1:0]     in_ready_c;
`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [2*N-1:0]   rr_rot;
`endif

    assign load = !out_valid_q || bus.out_ready;
    // Gated by rst_n so no channel is accepted while reset is held.
    assign xfer = rst_n && load && gnt_valid;

    // Grant selection.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
`ifdef STREAM_MUX_RR_EN
        // Doubled valid vector rotated by rr_ptr: bit k is channel (rr_ptr+k) mod N.
        rr_rot = {bus.in_valid, bus.in_valid} >> rr_ptr_q;
        if (bus.mode) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (!gnt_valid && rr_rot[k]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SEL_W'((32'(rr_ptr_q) + k) % N);
                end
            end
        end else
`endif
        begin
            // sel values >= N match no channel and therefore give no grant.
            for (int unsigned i = 0; i < N; i++) begin
                if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SEL_W'(i);
                end
            end
        end
    end

    // Data of the granted channel and one-hot ready.
    always_comb begin
        gnt_data   = '0;
        in_ready_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data      = bus.in_data[i*WIDTH +: WIDTH];
                in_ready_c[i] = xfer;
            end
        end
    end

    // Output stage next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (load) begin
            out_valid_d = gnt_valid;
        end
        if (xfer) begin
            out_data_d = gnt_data;
            out_chan_d = gnt_idx;
        end
    end

`ifdef STREAM_MUX_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer && bus.mode) begin
            rr_ptr_d = SEL_W'((32'(gnt_idx) + 1) % N);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter WIDTH, default 1, data width per channel in bits (>=1).
REQ-002 Parameter N, default 2, number of input channels (2..16).
REQ-003 Localparam SEL_W = max(1, clog2(N)); it is not overridable.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  per-channel valid.
REQ-008 in_ready  output  N  per-channel ready; combinational.
REQ-009 sel  input  SEL_W  channel select in fixed mode.
REQ-010 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  SEL_W  registered index of the source channel.
REQ-013 out_valid  output  1  registered output valid.
REQ-014 out_ready  input  1  downstream ready.

Function
REQ-015 The block SHALL hold one output register stage, with load = !out_valid | out_ready.
REQ-016 Fixed mode: the grant SHALL be channel sel when in_valid[sel]=1 and sel<N; otherwise there is no grant.
REQ-017 Round-robin mode: the grant SHALL be the first channel with in_valid=1, scanning from pointer rr_ptr upward modulo N.
REQ-018 in_ready[i] SHALL be 1 only when i is granted and load=1; at most one bit is set at a time.
REQ-019 On a transfer (in_valid[i] & in_ready[i]), the block SHALL capture in_data[i] into out_data and i into out_chan, and set out_valid=1 at the next edge (latency 1 cycle).
REQ-020 When load=1 and there is no grant, out_valid SHALL clear to 0; out_data and out_chan SHALL hold.
REQ-021 When out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL hold, and all in_ready SHALL be 0.
REQ-022 Back-to-back transfers SHALL sustain 1 word per cycle when out_ready=1 continuously.
REQ-023 rr_ptr SHALL update to (granted index + 1) mod N only on a round-robin transfer; it SHALL hold otherwise.
REQ-024 A change of mode or sel SHALL take effect in the same cycle's grant; rr_ptr SHALL be retained across mode switches.
REQ-025 The sel value is sampled only at transfer; changing sel while stalled SHALL NOT alter the held output.

Reset
REQ-026 While rst_n=0: out_valid=0, out_data=0, out_chan=0, rr_ptr=0, and all in_ready=0.
REQ-027 Reset asserted mid-transfer SHALL discard the held word; the first grant after release SHALL be evaluated from rr_ptr=0.

Configuration
REQ-028 Macro STREAM_MUX_RR_EN defined: round-robin logic and rr_ptr are present, and mode behaves per REQ-010.
REQ-029 Macro STREAM_MUX_RR_EN undefined: mode SHALL be ignored, the block SHALL always operate in fixed mode, and no rr_ptr register is built.

Verification
REQ-030 WIDTH=8, N=4, mode=0, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_chan=2.
REQ-031 mode=0, sel=1, in_valid=4'b0100 -> in_ready=0; out_valid drops to 0 after the held word drains.
REQ-032 mode=1 (RR_EN defined), all in_valid=1, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,3,0,1.
REQ-033 Word held with out_ready=0 for 3 cycles while sel changes 2->3 -> out_data and out_chan unchanged; in_ready=0; transfer completes when out_ready=1.
REQ-034 rst_n pulsed low mid-stream in RR mode -> out_valid=0 immediately; after release with all valid, first out_chan=0.
REQ-035 RR_EN undefined, mode=1, sel=3, all valid -> every out_chan=3.
